branch_predictor: RTL and testbench



---
 rtl/branch_predictor_pkg.sv | 26 ++
 rtl/bp_sat_ctr2.sv | 29 ++
 rtl/branch_predictor.sv | 87 ++++++++
 tb/tb_branch_predictor.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: bus widths, constants, counter states.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Bus typedefs describe the default 32-bit / 64-entry configuration.
package branch_predictor_pkg;

  localparam int InstAddrW = 32;
  localparam int BpIndexW  = 6;
  localparam int BpTagW    = InstAddrW - BpIndexW - 2;

  typedef logic [InstAddrW-1:0] InstAddrBus;
  typedef logic [BpIndexW-1:0]  BpIndexBus;
  typedef logic [BpTagW-1:0]    BpTagBus;

  localparam InstAddrBus ZeroWord = '0;
  localparam logic True      = 1'b1;
  localparam logic False     = 1'b0;
  localparam logic RstEnable = 1'b0;  // reset is active-low

  typedef enum logic [1:0] {
    CtrStrongNT = 2'b00,
    CtrWeakNT   = 2'b01,
    CtrWeakT    = 2'b10,
    CtrStrongT  = 2'b11
  } bp_ctr_t;

endpackage

// File: rtl/bp_sat_ctr2.sv
// Next state of a 2-bit saturating direction counter.
// Latency: combinational. Backpressure: none.
// Saturates at StrongT on taken and StrongNT on not-taken.
module bp_sat_ctr2
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      case (ctr)
        CtrStrongNT: ctr_next = CtrWeakNT;
        CtrWeakNT:   ctr_next = CtrWeakT;
        default:     ctr_next = CtrStrongT;
      endcase
    end else begin
      case (ctr)
        CtrStrongT: ctr_next = CtrWeakT;
        CtrWeakT:   ctr_next = CtrWeakNT;
        default:    ctr_next = CtrStrongNT;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side BTB with 2-bit bimodal counters, trained by EX resolution feedback.
// Latency: lookup is combinational from pc; updates become visible the cycle after the write.
// Backpressure: none; every update pulse is absorbed, independent of pipeline stall.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BpIndexW,
  parameter int ADDR_W     = InstAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pre_jmp_status,
  output logic [ADDR_W-1:0] pre_jmp_target,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
  output logic [31:0]       mispred_cnt_o
);

  localparam int Entries = 1 << INDEX_BITS;
  localparam int TagW    = ADDR_W - INDEX_BITS - 2;

  logic [Entries-1:0] valid;
  logic [TagW-1:0]    tag_mem [Entries];
  logic [ADDR_W-1:0]  tgt_mem [Entries];
  bp_ctr_t            ctr_mem [Entries];

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TagW-1:0]       rd_tag, wr_tag;
  logic                  rd_hit, wr_hit, upd_en, wr_en;
  bp_ctr_t               rd_ctr, wr_ctr, wr_ctr_next;
  logic [3:0]            unused_pc_lsb;

  // Instructions are word aligned, so the two low PC bits carry no information.
  assign unused_pc_lsb = {pc[1:0], upd_pc_i[1:0]};

  // Lookup path: reads pre-update contents, no bypass from a same-cycle write.
  assign rd_idx         = pc[INDEX_BITS+1:2];
  assign rd_tag         = pc[ADDR_W-1:INDEX_BITS+2];
  assign rd_ctr         = ctr_mem[rd_idx];
  assign rd_hit         = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign pre_jmp_status = rd_hit && rd_ctr[1];
  assign pre_jmp_target = pre_jmp_status ? tgt_mem[rd_idx] : pc + ADDR_W'(4);

  // Update path
  assign wr_idx = upd_pc_i[INDEX_BITS+1:2];
  assign wr_tag = upd_pc_i[ADDR_W-1:INDEX_BITS+2];
  assign wr_ctr = ctr_mem[wr_idx];
  assign wr_hit = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);
  assign upd_en = (rst != RstEnable) && upd_valid_i;
  // A not-taken miss leaves the entry alone; a taken miss allocates over whatever is there.
  assign wr_en  = upd_en && (wr_hit || upd_taken_i);

  bp_sat_ctr2 u_sat_ctr (
    .ctr      (wr_ctr),
    .taken    (upd_taken_i),
    .ctr_next (wr_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      ctr_mem[wr_idx] <= wr_hit ? wr_ctr_next : CtrWeakT;
      if (upd_taken_i) begin
        tgt_mem[wr_idx] <= upd_target_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid         <= '0;
      mispred_cnt_o <= ZeroWord;
    end else begin
      if (upd_valid_i && upd_taken_i) begin
        valid[wr_idx] <= True;
      end
      if (upd_valid_i && upd_mispred_i && (mispred_cnt_o != 32'hFFFF_FFFF)) begin
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table of per-cycle vectors plus hand sequences for reset and the mispredict counter.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        pre_jmp_status;
  logic [31:0] pre_jmp_target;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_mispred_i = 1'b0;
  logic [31:0] mispred_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pre_jmp_status (pre_jmp_status),
    .pre_jmp_target (pre_jmp_target),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i),
    .upd_mispred_i  (upd_mispred_i),
    .mispred_cnt_o  (mispred_cnt_o)
  );

  // Expected outputs are those seen during the cycle, before this cycle's update lands.
  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        um;
    logic        es;
    logic [31:0] et;
    logic [31:0] ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] p, input logic uv, input logic [31:0] upc,
                     input logic ut, input logic [31:0] utgt, input logic um,
                     input logic es, input logic [31:0] et, input logic [31:0] ec);
    vec_t v;
    v.pc = p; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.um = um;
    v.es = es; v.et = et; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic um);
    pc = p; upd_valid_i = uv; upd_pc_i = upc;
    upd_taken_i = ut; upd_target_i = utgt; upd_mispred_i = um;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string name, input logic [31:0] p,
                      input logic es, input logic [31:0] et);
    drive(p, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk({name, ".status"}, {31'h0, pre_jmp_status}, {31'h0, es});
    chk({name, ".target"}, pre_jmp_target, et);
  endtask

  initial begin
    //   pc            uv upc           ut utgt          um  es  et            ec
    add(32'h0000_0040, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0000_0044, 0); // after reset
    add(32'h0000_0040, 1, 32'h0000_0040, 1, 32'h0000_0100, 0, 0, 32'h0000_0044, 0); // alloc, same-cycle lookup
    add(32'h0000_0040, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0000_0100, 0); // ctr=2
    add(32'h0000_0140, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0000_0144, 0); // tag mismatch
    add(32'h0000_0040, 1, 32'h0000_0040, 1, 32'h0000_0100, 0, 1, 32'h0000_0100, 0); // 2->3
    add(32'h0000_0040, 1, 32'h0000_0040, 1, 32'h0000_0100, 0, 1, 32'h0000_0100, 0); // 3->3
    add(32'h0000_0040, 1, 32'h0000_0040, 0, 32'h0,        0, 1, 32'h0000_0100, 0); // 3->2
    add(32'h0000_0040, 1, 32'h0000_0040, 0, 32'h0,        0, 1, 32'h0000_0100, 0); // 2->1
    add(32'h0000_0040, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0000_0044, 0); // ctr=1 not taken
    add(32'h0000_0040, 1, 32'h0000_0040, 1, 32'h0000_0180, 1, 0, 32'h0000_0044, 0); // 1->2, new target
    add(32'h0000_0040, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0000_0180, 1);
    add(32'h0000_0200, 1, 32'h0000_0200, 0, 32'h0000_0999, 0, 0, 32'h0000_0204, 1); // NT miss
    add(32'h0000_0200, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0000_0204, 1); // no alloc
    add(32'h0000_0080, 1, 32'h0000_0080, 1, 32'h0000_0300, 0, 0, 32'h0000_0084, 1); // same-cycle alloc
    add(32'h0000_0080, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0000_0300, 1);
    add(32'h0000_00C0, 1, 32'h0000_0042, 1, 32'h0000_0400, 0, 0, 32'h0000_00C4, 1); // low bits ignored
    add(32'h0000_0040, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0000_0400, 1);
    add(32'hFFFF_FFFC, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0000_0000, 1); // pc+4 wraps

    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].um);
      @(negedge clk);
      chk($sformatf("vec%0d.status", i), {31'h0, pre_jmp_status}, {31'h0, vecs[i].es});
      chk($sformatf("vec%0d.target", i), pre_jmp_target, vecs[i].et);
      chk($sformatf("vec%0d.cnt", i), mispred_cnt_o, vecs[i].ec);
      tick();
    end

    // Fresh reset, then five taken allocations with mispredict on three of them.
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [4:0] mp_pat;
      mp_pat = 5'b01101;
      drive(32'h0, 1'b1, 32'h40 + 32'(4 * k), 1'b1, 32'h800 + 32'(4 * k), mp_pat[k]);
      tick();
    end
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("cnt_after_5", mispred_cnt_o, 32'd3);
    look("trained_48", 32'h0000_0048, 1'b1, 32'h0000_0808);
    look("trained_50", 32'h0000_0050, 1'b1, 32'h0000_0810);

    // Reset mid-operation with an update pulse in the reset cycle, which must be ignored.
    rst = 1'b0;
    drive(32'h0, 1'b1, 32'h0000_0060, 1'b1, 32'h0000_0900, 1'b1);
    tick();
    rst = 1'b1;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("cnt_after_rst", mispred_cnt_o, 32'd0);
    look("rst_40", 32'h0000_0040, 1'b0, 32'h0000_0044);
    look("rst_48", 32'h0000_0048, 1'b0, 32'h0000_004C);
    look("rst_50", 32'h0000_0050, 1'b0, 32'h0000_0054);
    look("rst_60", 32'h0000_0060, 1'b0, 32'h0000_0064);
    tick();
    chk("cnt_held", mispred_cnt_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
